// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: round-robin arbiter that shares one single-ported memory
// between instruction fetch (IF) and the data-memory controller (DM), with an Ack watchdog.
module mem_port_arbiter #(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = 255
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            IF_Req,
    input  logic [AW-1:0]   IF_Address,
    output logic [DW-1:0]   IF_Data,
    output logic            IF_Ready,
    output logic            IF_Stall,
    input  logic            DM_Read,
    input  logic [DW/8-1:0] DM_Write,
    input  logic [AW-1:0]   DM_Address,
    input  logic [DW-1:0]   DM_DataIn,
    output logic [DW-1:0]   DM_DataOut,
    output logic            DM_Ready,
    output logic            DM_Stall,
    output logic            Mem_ReadEnable,
    output logic [DW/8-1:0] Mem_WriteEnable,
    output logic [AW-1:0]   Mem_Address,
    output logic [DW-1:0]   Mem_DataOut,
    input  logic [DW-1:0]   Mem_DataIn,
    input  logic            Mem_Ack,
    output logic            Timeout
);

    localparam int         BW       = DW / 8;
    localparam logic [7:0] WD_LIMIT = 8'(TIMEOUT);
    localparam bit         WD_EN    = (TIMEOUT != 0);

    typedef enum logic [1:0] {S_IDLE, S_IF_ACC, S_DM_ACC, S_RESP} state_t;

    state_t          r_state;
    state_t          w_next_state;
    logic            r_last_dm;
    logic            r_win_dm;
    logic [7:0]      r_wd_cnt;
    logic            r_mem_re;
    logic [BW-1:0]   r_mem_we;
    logic [AW-1:0]   r_mem_addr;
    logic [DW-1:0]   r_mem_wdata;
    logic [DW-1:0]   r_if_data;
    logic [DW-1:0]   r_dm_data;
    logic            r_if_ready;
    logic            r_dm_ready;
    logic            r_timeout;

    logic            w_dm_req;
    logic            w_grant_dm;
    logic            w_grant_if;
    logic            w_in_acc;
    logic            w_wd_fire;
    logic            w_acc_done;
    logic [DW-1:0]   w_rd_data;

    assign w_dm_req   = DM_Read | (|DM_Write);
    // On a tie the port that did not win last time goes first.
    assign w_grant_dm = w_dm_req & (~IF_Req | ~r_last_dm);
    assign w_grant_if = IF_Req & ~w_grant_dm;
    assign w_in_acc   = (r_state == S_IF_ACC) || (r_state == S_DM_ACC);
    assign w_wd_fire  = WD_EN && w_in_acc && !Mem_Ack && (r_wd_cnt == WD_LIMIT);
    assign w_acc_done = w_in_acc && (Mem_Ack || w_wd_fire);
    assign w_rd_data  = Mem_Ack ? Mem_DataIn : '0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= S_IDLE;
        else      r_state <= w_next_state;
    end

    always_comb begin
        // NOTE: default assigned first so every path drives it and no latch is inferred.
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_grant_dm)      w_next_state = S_DM_ACC;
                else if (w_grant_if) w_next_state = S_IF_ACC;
            end
            S_IF_ACC, S_DM_ACC: if (w_acc_done) w_next_state = S_RESP;
            S_RESP:             w_next_state = S_IDLE;
            default:            w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_last_dm   <= 1'b0;
            r_win_dm    <= 1'b0;
            r_wd_cnt    <= '0;
            r_mem_re    <= 1'b0;
            r_mem_we    <= '0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_if_data   <= '0;
            r_dm_data   <= '0;
            r_if_ready  <= 1'b0;
            r_dm_ready  <= 1'b0;
            r_timeout   <= 1'b0;
        end else begin
            // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
            r_if_ready <= 1'b0;
            r_dm_ready <= 1'b0;
            if (r_state == S_IDLE && (w_grant_dm || w_grant_if)) begin
                r_win_dm <= w_grant_dm;
                r_wd_cnt <= 8'd1;
                if (w_grant_dm) begin
                    r_mem_addr  <= DM_Address;
                    r_mem_wdata <= DM_DataIn;
                    r_mem_we    <= DM_Write;
                    r_mem_re    <= ~(|DM_Write);
                end else begin
                    r_mem_addr  <= IF_Address;
                    r_mem_wdata <= '0;
                    r_mem_we    <= '0;
                    r_mem_re    <= 1'b1;
                end
            end else if (w_acc_done) begin
                r_mem_re  <= 1'b0;
                r_mem_we  <= '0;
                r_wd_cnt  <= '0;
                r_last_dm <= r_win_dm;
                if (w_wd_fire) r_timeout <= 1'b1;
                if (r_win_dm) begin
                    r_dm_ready <= 1'b1;
                    // A write leaves the read-data register untouched.
                    if (r_mem_we == '0) r_dm_data <= w_rd_data;
                end else begin
                    r_if_ready <= 1'b1;
                    r_if_data  <= w_rd_data;
                end
            end else if (w_in_acc) begin
                r_wd_cnt <= r_wd_cnt + 8'd1;
            end
        end
    end

    assign IF_Data         = r_if_data;
    assign IF_Ready        = r_if_ready;
    assign DM_DataOut      = r_dm_data;
    assign DM_Ready        = r_dm_ready;
    assign Mem_ReadEnable  = r_mem_re;
    assign Mem_WriteEnable = r_mem_we;
    assign Mem_Address     = r_mem_addr;
    assign Mem_DataOut     = r_mem_wdata;
    assign Timeout         = r_timeout;
    // Stalls are held low during reset so that every output reads 0 there.
    assign IF_Stall        = rst & IF_Req & ~r_if_ready;
    assign DM_Stall        = rst & w_dm_req & ~r_dm_ready;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed stimulus with a response scoreboard; a forked monitor
// pops the expected response whenever IF_Ready or DM_Ready pulses.
module tb_mem_port_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int BW = DW / 8;

    logic          clk;
    logic          rst;
    logic          IF_Req;
    logic [AW-1:0] IF_Address;
    logic [DW-1:0] IF_Data;
    logic          IF_Ready;
    logic          IF_Stall;
    logic          DM_Read;
    logic [BW-1:0] DM_Write;
    logic [AW-1:0] DM_Address;
    logic [DW-1:0] DM_DataIn;
    logic [DW-1:0] DM_DataOut;
    logic          DM_Ready;
    logic          DM_Stall;
    logic          Mem_ReadEnable;
    logic [BW-1:0] Mem_WriteEnable;
    logic [AW-1:0] Mem_Address;
    logic [DW-1:0] Mem_DataOut;
    logic [DW-1:0] Mem_DataIn;
    logic          Mem_Ack;
    logic          Timeout;

    mem_port_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(4)) dut (
        .clk(clk), .rst(rst),
        .IF_Req(IF_Req), .IF_Address(IF_Address), .IF_Data(IF_Data),
        .IF_Ready(IF_Ready), .IF_Stall(IF_Stall),
        .DM_Read(DM_Read), .DM_Write(DM_Write), .DM_Address(DM_Address),
        .DM_DataIn(DM_DataIn), .DM_DataOut(DM_DataOut), .DM_Ready(DM_Ready),
        .DM_Stall(DM_Stall),
        .Mem_ReadEnable(Mem_ReadEnable), .Mem_WriteEnable(Mem_WriteEnable),
        .Mem_Address(Mem_Address), .Mem_DataOut(Mem_DataOut),
        .Mem_DataIn(Mem_DataIn), .Mem_Ack(Mem_Ack), .Timeout(Timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic        is_dm;
        logic [31:0] data;
    } exp_t;

    exp_t        sb[$];
    int          errors = 0;
    int          checks = 0;
    logic [31:0] exp_dm_data = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, wanted %0h", name, act, exp);
        end
    endtask

    task automatic push_if(input logic [31:0] d);
        sb.push_back('{is_dm: 1'b0, data: d});
    endtask

    task automatic push_dm_rd(input logic [31:0] d);
        exp_dm_data = d;
        sb.push_back('{is_dm: 1'b1, data: d});
    endtask

    task automatic push_dm_wr();
        sb.push_back('{is_dm: 1'b1, data: exp_dm_data});
    endtask

    // Memory model: wait for a command, optionally delay, then Ack with read data for one cycle.
    task automatic ack_next(input int delay, input logic [31:0] d, input logic [31:0] addr);
        int n = 0;
        while (!(Mem_ReadEnable || (|Mem_WriteEnable)) && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("ack_wait_enable", Mem_ReadEnable | (|Mem_WriteEnable), 1);
        check("ack_addr", Mem_Address, addr);
        repeat (delay) @(negedge clk);
        Mem_Ack    = 1'b1;
        Mem_DataIn = d;
        @(negedge clk);
        Mem_Ack    = 1'b0;
        Mem_DataIn = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not reach its end");
        $fatal(1, "global timeout");
    end

    initial begin
        int n;
        rst        = 1'b0;
        IF_Req     = 1'b1;
        IF_Address = '0;
        DM_Read    = 1'b1;
        DM_Write   = '0;
        DM_Address = '0;
        DM_DataIn  = '0;
        Mem_DataIn = '0;
        Mem_Ack    = 1'b0;

        fork
            forever begin
                exp_t e;
                @(negedge clk);
                if (rst && (IF_Ready || DM_Ready)) begin
                    if (sb.size() == 0) begin
                        check("spurious_ready", {IF_Ready, DM_Ready}, 2'b00);
                    end else begin
                        e = sb.pop_front();
                        check("resp_port", {IF_Ready, DM_Ready}, e.is_dm ? 2'b01 : 2'b10);
                        check("resp_data", e.is_dm ? DM_DataOut : IF_Data, e.data);
                    end
                end
            end
        join_none

        // Reset with requests pending: everything reads 0.
        repeat (2) @(negedge clk);
        check("rst_stall", {IF_Stall, DM_Stall}, 2'b00);
        check("rst_ctrl", {IF_Ready, DM_Ready, Mem_ReadEnable, Mem_WriteEnable, Timeout}, 0);
        check("rst_mem_addr", Mem_Address, 0);
        check("rst_mem_wdata", Mem_DataOut, 0);
        check("rst_if_data", IF_Data, 0);
        check("rst_dm_data", DM_DataOut, 0);
        IF_Req  = 1'b0;
        DM_Read = 1'b0;
        rst     = 1'b1;
        @(negedge clk);

        // Single IF fetch, Ack on the first command cycle.
        IF_Address = 32'h100;
        IF_Req     = 1'b1;
        push_if(32'h8C010004);
        @(negedge clk);
        check("t1_re", Mem_ReadEnable, 1);
        check("t1_addr", Mem_Address, 32'h100);
        check("t1_if_stall", IF_Stall, 1);
        Mem_Ack    = 1'b1;
        Mem_DataIn = 32'h8C010004;
        @(negedge clk);
        Mem_Ack    = 1'b0;
        Mem_DataIn = '0;
        check("t1_re_drop", Mem_ReadEnable, 0);
        check("t1_ready", IF_Ready, 1);
        check("t1_stall_clear", IF_Stall, 0);
        IF_Req = 1'b0;
        @(negedge clk);
        check("t1_ready_once", IF_Ready, 0);

        // Byte write (read also set, write wins) while IF waits; inputs change mid-access.
        IF_Address = 32'h404;
        IF_Req     = 1'b1;
        DM_Write   = 4'b0100;
        DM_Read    = 1'b1;
        DM_Address = 32'h203;
        DM_DataIn  = 32'h33333333;
        push_dm_wr();
        push_if(32'h11110404);
        @(negedge clk);
        check("t3_we", Mem_WriteEnable, 4'b0100);
        check("t3_re", Mem_ReadEnable, 0);
        check("t3_addr", Mem_Address, 32'h203);
        check("t3_wdata", Mem_DataOut, 32'h33333333);
        check("t3_stalls", {IF_Stall, DM_Stall}, 2'b11);
        DM_Address = 32'hFFF;
        DM_DataIn  = '0;
        DM_Write   = 4'b1111;
        @(negedge clk);
        check("t3_we_hold", Mem_WriteEnable, 4'b0100);
        check("t3_addr_hold", Mem_Address, 32'h203);
        check("t3_wdata_hold", Mem_DataOut, 32'h33333333);
        ack_next(0, 32'hDEADBEEF, 32'h203);
        check("t3_dm_ready", DM_Ready, 1);
        check("t3_if_stall", IF_Stall, 1);
        check("t3_we_drop", Mem_WriteEnable, 0);
        DM_Write = '0;
        DM_Read  = 1'b0;
        ack_next(1, 32'h11110404, 32'h404);
        IF_Req = 1'b0;

        // Both request: DM first, then IF; both again: DM first.
        IF_Address = 32'h200;
        IF_Req     = 1'b1;
        DM_Address = 32'h300;
        DM_Read    = 1'b1;
        push_dm_rd(32'hD0000001);
        push_if(32'h10000002);
        ack_next(1, 32'hD0000001, 32'h300);
        DM_Read = 1'b0;
        ack_next(0, 32'h10000002, 32'h200);
        IF_Req = 1'b0;
        IF_Address = 32'h204;
        IF_Req     = 1'b1;
        DM_Address = 32'h304;
        DM_Read    = 1'b1;
        push_dm_rd(32'hD0000003);
        push_if(32'h10000004);
        ack_next(0, 32'hD0000003, 32'h304);
        DM_Read = 1'b0;
        ack_next(2, 32'h10000004, 32'h204);
        IF_Req = 1'b0;

        // After a DM-only access, a tie goes to IF.
        DM_Address = 32'h308;
        DM_Read    = 1'b1;
        push_dm_rd(32'hD0000005);
        ack_next(0, 32'hD0000005, 32'h308);
        DM_Read = 1'b0;
        IF_Address = 32'h208;
        IF_Req     = 1'b1;
        DM_Address = 32'h30C;
        DM_Read    = 1'b1;
        push_if(32'h10000006);
        push_dm_rd(32'hD0000007);
        ack_next(0, 32'h10000006, 32'h208);
        IF_Req = 1'b0;
        ack_next(0, 32'hD0000007, 32'h30C);
        DM_Read = 1'b0;
        check("hold_if_data", IF_Data, 32'h10000006);

        // Stray Ack in IDLE; requester drops its request mid-access.
        Mem_Ack    = 1'b1;
        Mem_DataIn = 32'h55555555;
        @(negedge clk);
        Mem_Ack    = 1'b0;
        Mem_DataIn = '0;
        check("t6_idle_cmd", {Mem_ReadEnable, Mem_WriteEnable}, 0);
        @(negedge clk);
        check("t6_no_ready", {IF_Ready, DM_Ready}, 2'b00);
        check("t6_dm_hold", DM_DataOut, 32'hD0000007);
        DM_Address = 32'h500;
        DM_Read    = 1'b1;
        push_dm_rd(32'h66666666);
        @(negedge clk);
        check("t6_re", Mem_ReadEnable, 1);
        DM_Read = 1'b0;
        @(negedge clk);
        check("t6_re_held", Mem_ReadEnable, 1);
        check("t6_dm_stall", DM_Stall, 0);
        ack_next(0, 32'h66666666, 32'h500);
        check("t6_ready", DM_Ready, 1);
        repeat (3) @(negedge clk);
        check("t4_pre_timeout", Timeout, 0);

        // Watchdog: no Ack, enables held for exactly 4 cycles, data returned as 0.
        DM_Address = 32'h600;
        DM_Read    = 1'b1;
        Mem_DataIn = 32'hBADBAD00;
        push_dm_rd(32'h0);
        @(negedge clk);
        n = 0;
        while (Mem_ReadEnable && n < 10) begin
            n++;
            @(negedge clk);
        end
        check("t4_acc_cycles", n, 4);
        check("t4_ready", DM_Ready, 1);
        check("t4_timeout", Timeout, 1);
        DM_Read    = 1'b0;
        Mem_DataIn = '0;
        repeat (3) @(negedge clk);
        check("t4_sticky", Timeout, 1);

        // Reset during a DM access, IF pending: outputs clear at once, no stale DM_Ready.
        DM_Address = 32'h700;
        DM_Read    = 1'b1;
        @(negedge clk);
        check("t5_in_acc", Mem_ReadEnable, 1);
        IF_Address = 32'h704;
        IF_Req     = 1'b1;
        #2 rst = 1'b0;
        #1;
        check("t5_rst_ctrl", {IF_Ready, DM_Ready, Mem_ReadEnable, Mem_WriteEnable, Timeout, IF_Stall, DM_Stall}, 0);
        check("t5_rst_addr", Mem_Address, 0);
        check("t5_rst_dm_data", DM_DataOut, 0);
        DM_Read     = 1'b0;
        exp_dm_data = '0;
        @(negedge clk);
        rst = 1'b1;
        push_if(32'h77777777);
        ack_next(1, 32'h77777777, 32'h704);
        IF_Req = 1'b0;
        repeat (4) @(negedge clk);
        check("t5_timeout_clear", Timeout, 0);

        repeat (2) @(negedge clk);
        check("sb_empty", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
